landing_response_unit: RTL and testbench
========================================

Name: landing_response_unit

Overview:
- Consumer-side counterpart of the ECSU weather classifier.
- Takes ECSU's `severe_weather`, `emergency_landing_alert` and `ECSU_state` and turns them into cockpit annunciation: caution/warning lamp and alarm.
- On emergency, handles the pilot acknowledge handshake with timeout, then sequences descent, gear extension and touchdown from an altitude feed.
- Sits between ECSU and the cockpit/flight-control interface.

Parameters:
- ACK_TIMEOUT, 50, cycles allowed for pilot_ack after the alarm starts (>=2).
- GEAR_ALT, 300, altitude (12-bit unsigned units) at or below which gear is commanded down.
- BLINK_HALF, 4, warning-lamp half-period in cycles (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- severe_weather  input  1  from ECSU.
- emergency_landing_alert  input  1  from ECSU.
- ECSU_state  input  2  ECSU state code (0 normal, 1 caution, 2 severe, 3 emergency).
- pilot_ack  input  1  single-cycle or level pilot acknowledge.
- altitude  input  12  unsigned current altitude.
- warning_lamp  output  1  cockpit lamp.
- alarm  output  1  audible alarm.
- descent_cmd  output  1  descent command to flight control.
- gear_down  output  1  landing-gear extend command.
- auto_pilot  output  1  set when descent was entered by timeout.
- landing_complete  output  1  touchdown reached.
- lru_state  output  3  current state code.

Behaviour:
- Reset: one clock, CLK; reset is asynchronous and active-high on RST. All outputs go to 0, lru_state=0 (IDLE), and all counters clear.
- Output timing: all outputs are registered and take their new-state values on the same edge as the transition, giving 1-cycle latency from input to output.
- States: IDLE=0, CAUTION=1, WARNING=2, ALERT=3, DESCENT=4, GEAR=5, LANDED=6. Code 7 is illegal and forces IDLE with all outputs 0.
- Priority in IDLE, CAUTION and WARNING (checked in this order):
  - emergency_landing_alert -> ALERT.
  - else severe_weather -> WARNING.
  - else ECSU_state==1 -> CAUTION.
  - else -> IDLE.
- Lamp and alarm per state:
  - IDLE: lamp 0, alarm 0.
  - CAUTION: lamp steady 1.
  - WARNING: lamp is 1 on entry, then toggles every BLINK_HALF cycles. The blink counter clears on every WARNING entry.
  - ALERT onward: lamp steady 1.
- Latching: from ALERT onward, severe_weather, ECSU_state and emergency_landing_alert are ignored. The emergency is latched until RST.
- ALERT:
  - alarm=1.
  - ack counter increments each cycle in ALERT, starting at 0 on the entry edge.
  - pilot_ack=1 -> DESCENT with auto_pilot=0.
  - Counter reaching ACK_TIMEOUT-1 with no ack -> DESCENT with auto_pilot=1, i.e. ACK_TIMEOUT cycles in ALERT.
  - pilot_ack on the timeout cycle: ack wins, auto_pilot=0.
- DESCENT:
  - alarm=0, descent_cmd=1.
  - altitude<=GEAR_ALT -> GEAR.
  - Already at or below GEAR_ALT on entry: DESCENT still lasts exactly 1 cycle.
- GEAR:
  - descent_cmd=1, gear_down=1.
  - altitude==0 -> LANDED.
  - altitude rising above GEAR_ALT does not retract the gear.
- LANDED:
  - descent_cmd=0, gear_down stays 1, landing_complete=1, lamp stays 1.
  - Terminal until RST.
- auto_pilot: holds its value from ALERT exit until RST.
- Reset mid-sequence (any state): immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: LRU_AUTO_LAND_EN.
- Defined: ALERT timeout behaves as specified above (auto descent, auto_pilot=1).
- Undefined:
  - No timeout: ALERT holds with alarm=1 until pilot_ack.
  - auto_pilot is tied to 0.
  - The ack counter is not built.

Test Plan:
1. ECSU_state=1, others 0 -> lru_state=1 and lamp=1 next cycle. Then ECSU_state=0 -> IDLE, lamp=0.
2. severe_weather=1 held 20 cycles -> lru_state=2, lamp pattern 1111 0000 1111... (BLINK_HALF=4). Drop severe_weather with ECSU_state=1 -> CAUTION, lamp steady 1.
3. emergency_landing_alert=1 and severe_weather=1 together from IDLE -> ALERT (alert priority), alarm=1. pilot_ack at cycle 10 -> DESCENT, auto_pilot=0, alarm=0.
4. With LRU_AUTO_LAND_EN, no ack -> exactly 50 cycles in ALERT, then DESCENT with auto_pilot=1. Ack on cycle 50 -> auto_pilot=0. Without the macro, 200 cycles still in ALERT.
5. In DESCENT, altitude ramps 1000->0 in steps of 100 -> gear_down asserts the cycle after altitude=300 is seen; LANDED with landing_complete=1 after altitude=0. Later severe_weather toggling has no effect.
6. RST pulsed while in GEAR -> all outputs 0 and lru_state=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/landing_response_unit.sv
// rtl/landing_response_unit.sv - cockpit annunciation and emergency landing sequencer
// Optional macro LRU_AUTO_LAND_EN: unacknowledged ALERT times out into an auto descent.
module landing_response_unit #(
  parameter int unsigned ACK_TIMEOUT = 50,
  parameter int unsigned GEAR_ALT    = 300,
  parameter int unsigned BLINK_HALF  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        severe_weather,
  input  logic        emergency_landing_alert,
  input  logic [1:0]  ECSU_state,
  input  logic        pilot_ack,
  input  logic [11:0] altitude,
  output logic        warning_lamp,
  output logic        alarm,
  output logic        descent_cmd,
  output logic        gear_down,
  output logic        auto_pilot,
  output logic        landing_complete,
  output logic [2:0]  lru_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAUTION = 3'd1,
    S_WARNING = 3'd2,
    S_ALERT   = 3'd3,
    S_DESCENT = 3'd4,
    S_GEAR    = 3'd5,
    S_LANDED  = 3'd6
  } state_t;

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [11:0]   GEAR_ALT_L = 12'(GEAR_ALT);

  if (ACK_TIMEOUT < 2 || BLINK_HALF < 1) begin : g_param_check
    $error("landing_response_unit: ACK_TIMEOUT must be >= 2 and BLINK_HALF >= 1");
  end

  state_t          state_q;
  logic            lamp_q, alarm_q, descent_q, gear_q, landed_q;
  logic [BW-1:0]   blink_cnt_q;

`ifdef LRU_AUTO_LAND_EN
  localparam int AW = $clog2(ACK_TIMEOUT);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
  logic [AW-1:0]   ack_cnt_q;
  logic            auto_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lamp_q      <= 1'b0;
      alarm_q     <= 1'b0;
      descent_q   <= 1'b0;
      gear_q      <= 1'b0;
      landed_q    <= 1'b0;
      blink_cnt_q <= '0;
`ifdef LRU_AUTO_LAND_EN
      ack_cnt_q   <= '0;
      auto_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_CAUTION, S_WARNING: begin
          alarm_q   <= 1'b0;
          descent_q <= 1'b0;
          gear_q    <= 1'b0;
          landed_q  <= 1'b0;
          if (emergency_landing_alert) begin
            state_q <= S_ALERT;
            lamp_q  <= 1'b1;
            alarm_q <= 1'b1;
`ifdef LRU_AUTO_LAND_EN
            ack_cnt_q <= '0;
`endif
          end else if (severe_weather) begin
            state_q <= S_WARNING;
            // Fresh entry restarts the blink phase with the lamp lit.
            if (state_q != S_WARNING) begin
              lamp_q      <= 1'b1;
              blink_cnt_q <= '0;
            end else if (blink_cnt_q == BLINK_LAST) begin
              lamp_q      <= ~lamp_q;
              blink_cnt_q <= '0;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end else if (ECSU_state == 2'd1) begin
            state_q <= S_CAUTION;
            lamp_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            lamp_q  <= 1'b0;
          end
        end
        S_ALERT: begin
          if (pilot_ack) begin
            state_q   <= S_DESCENT;
            alarm_q   <= 1'b0;
            descent_q <= 1'b1;
`ifdef LRU_AUTO_LAND_EN
            auto_q    <= 1'b0;
          end else if (ack_cnt_q == ACK_LAST) begin
            state_q   <= S_DESCENT;
            alarm_q   <= 1'b0;
            descent_q <= 1'b1;
            auto_q    <= 1'b1;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
`endif
          end
        end
        S_DESCENT: begin
          if (altitude <= GEAR_ALT_L) begin
            state_q <= S_GEAR;
            gear_q  <= 1'b1;
          end
        end
        S_GEAR: begin
          if (altitude == 12'd0) begin
            state_q   <= S_LANDED;
            descent_q <= 1'b0;
            landed_q  <= 1'b1;
          end
        end
        S_LANDED: begin
          state_q <= S_LANDED;
        end
        default: begin
          state_q   <= S_IDLE;
          lamp_q    <= 1'b0;
          alarm_q   <= 1'b0;
          descent_q <= 1'b0;
          gear_q    <= 1'b0;
          landed_q  <= 1'b0;
`ifdef LRU_AUTO_LAND_EN
          auto_q    <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign warning_lamp     = lamp_q;
  assign alarm            = alarm_q;
  assign descent_cmd      = descent_q;
  assign gear_down        = gear_q;
  assign landing_complete = landed_q;
  assign lru_state        = state_q;
`ifdef LRU_AUTO_LAND_EN
  assign auto_pilot       = auto_q;
`else
  assign auto_pilot       = 1'b0;
`endif

endmodule

// File: tb/tb_landing_response_unit.sv
// tb/tb_landing_response_unit.sv - randomized model-based bench for landing_response_unit
// Honors LRU_AUTO_LAND_EN to match the timeout build of the design.
module tb_landing_response_unit;

  localparam int unsigned ACK_TIMEOUT = 50;
  localparam int unsigned GEAR_ALT    = 300;
  localparam int unsigned BLINK_HALF  = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        severe_weather = 1'b0;
  logic        emergency_landing_alert = 1'b0;
  logic [1:0]  ECSU_state = 2'd0;
  logic        pilot_ack = 1'b0;
  logic [11:0] altitude = 12'd0;
  logic        warning_lamp, alarm, descent_cmd, gear_down, auto_pilot, landing_complete;
  logic [2:0]  lru_state;

  int checks = 0;
  int errors = 0;

  // Reference model: abstract mode plus "time spent" ages.
  int m_state;
  int m_warn_age;
  int m_alert_age;
  bit m_auto;

  landing_response_unit #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .GEAR_ALT(GEAR_ALT),
    .BLINK_HALF(BLINK_HALF)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .severe_weather(severe_weather),
    .emergency_landing_alert(emergency_landing_alert),
    .ECSU_state(ECSU_state),
    .pilot_ack(pilot_ack),
    .altitude(altitude),
    .warning_lamp(warning_lamp),
    .alarm(alarm),
    .descent_cmd(descent_cmd),
    .gear_down(gear_down),
    .auto_pilot(auto_pilot),
    .landing_complete(landing_complete),
    .lru_state(lru_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [8:0] dut_outs();
    return {warning_lamp, alarm, descent_cmd, gear_down, auto_pilot, landing_complete, lru_state};
  endfunction

  function automatic logic [8:0] model_outs();
    logic lamp;
    logic ap;
    if (m_state == 0) lamp = 1'b0;
    else if (m_state == 2) lamp = ((m_warn_age / BLINK_HALF) % 2) == 0;
    else lamp = 1'b1;
`ifdef LRU_AUTO_LAND_EN
    ap = m_auto;
`else
    ap = 1'b0;
`endif
    return {lamp, m_state == 3, (m_state == 4 || m_state == 5), (m_state == 5 || m_state == 6),
            ap, m_state == 6, 3'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_warn_age = 0; m_alert_age = 0; m_auto = 0;
  endtask

  task automatic model_step();
    int ns;
    ns = m_state;
    case (m_state)
      0, 1, 2: begin
        if (emergency_landing_alert) begin ns = 3; m_alert_age = 0; end
        else if (severe_weather) begin
          if (m_state == 2) m_warn_age++; else m_warn_age = 0;
          ns = 2;
        end else if (ECSU_state == 2'd1) ns = 1;
        else ns = 0;
      end
      3: begin
        if (pilot_ack) begin ns = 4; m_auto = 0; end
        else begin
          m_alert_age++;
`ifdef LRU_AUTO_LAND_EN
          if (m_alert_age == ACK_TIMEOUT) begin ns = 4; m_auto = 1; end
`endif
        end
      end
      4: if (altitude <= GEAR_ALT) ns = 5;
      5: if (altitude == 0) ns = 6;
      default: ns = m_state;
    endcase
    m_state = ns;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic drive(input logic sw, input logic ela, input logic [1:0] es,
                       input logic ack, input logic [11:0] alt);
    severe_weather = sw; emergency_landing_alert = ela; ECSU_state = es;
    pilot_ack = ack; altitude = alt;
  endtask

  task automatic apply_reset();
    drive(0, 0, 2'd0, 0, 12'd0);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 1, 2'd3, 1, 12'd0);
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_outs() !== 9'd0) begin
      errors++; $display("FAIL reset_async: got %b expected %b", dut_outs(), 9'd0);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (dut_outs() !== 9'd0) begin
      errors++; $display("FAIL reset_held: got %b expected %b", dut_outs(), 9'd0);
    end
    apply_reset();
  endtask

  task automatic test_caution();
    apply_reset();
    drive(0, 0, 2'd1, 0, 12'd2000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL caution cyc %0d: got %b expected %b", i, dut_outs(), model_outs());
      end
    end
    checks++;
    if (lru_state !== 3'd1 || warning_lamp !== 1'b1) begin
      errors++; $display("FAIL caution_state: got st=%0d lamp=%b expected st=1 lamp=1", lru_state, warning_lamp);
    end
    drive(0, 0, 2'd0, 0, 12'd2000);
    tick();
    checks++;
    if (lru_state !== 3'd0 || warning_lamp !== 1'b0) begin
      errors++; $display("FAIL caution_exit: got st=%0d lamp=%b expected st=0 lamp=0", lru_state, warning_lamp);
    end
  endtask

  task automatic test_warning_blink();
    logic [19:0] pat;
    logic [19:0] want;
    want = 20'b11110000111100001111;
    apply_reset();
    drive(1, 0, 2'd0, 0, 12'd2000);
    for (int i = 0; i < 20; i++) begin
      tick();
      pat[19 - i] = warning_lamp;
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL warning cyc %0d: got %b expected %b", i, dut_outs(), model_outs());
      end
    end
    checks++;
    if (pat !== want) begin
      errors++; $display("FAIL warning_pattern: got %b expected %b", pat, want);
    end
    // Re-entry after a short CAUTION must restart the blink phase.
    drive(0, 0, 2'd1, 0, 12'd2000);
    tick();
    checks++;
    if (lru_state !== 3'd1 || warning_lamp !== 1'b1) begin
      errors++; $display("FAIL warning_to_caution: got st=%0d lamp=%b expected st=1 lamp=1", lru_state, warning_lamp);
    end
    drive(1, 0, 2'd1, 0, 12'd2000);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL warning_reentry cyc %0d: got %b expected %b", i, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_random_classifier();
    logic sw;
    logic [1:0] es;
    apply_reset();
    sw = 0; es = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) sw = ~sw;
      if ($urandom_range(0, 3) == 0) es = 2'($urandom_range(0, 3));
      drive(sw, 0, es, 1'($urandom_range(0, 1)), 12'($urandom));
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL rand_class cyc %0d: got %b expected %b", i, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_alert_ack();
    apply_reset();
    drive(1, 1, 2'd2, 0, 12'd2000);
    tick();
    checks++;
    if (lru_state !== 3'd3 || alarm !== 1'b1) begin
      errors++; $display("FAIL alert_priority: got st=%0d alarm=%b expected st=3 alarm=1", lru_state, alarm);
    end
    for (int i = 1; i < 10; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 12'd2000);
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL alert_hold cyc %0d: got %b expected %b", i, dut_outs(), model_outs());
      end
    end
    drive(0, 0, 2'd0, 1, 12'd2000);
    tick();
    drive(0, 0, 2'd0, 0, 12'd2000);
    checks++;
    if (lru_state !== 3'd4 || auto_pilot !== 1'b0 || alarm !== 1'b0 || descent_cmd !== 1'b1) begin
      errors++; $display("FAIL alert_ack: got st=%0d ap=%b alarm=%b dc=%b expected st=4 ap=0 alarm=0 dc=1",
                         lru_state, auto_pilot, alarm, descent_cmd);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    apply_reset();
    drive(0, 1, 2'd0, 0, 12'd2000);
    tick();
    drive(0, 0, 2'd0, 0, 12'd2000);
`ifdef LRU_AUTO_LAND_EN
    while (lru_state === 3'd3 && n < 300) begin
      n++;
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL timeout cyc %0d: got %b expected %b", n, dut_outs(), model_outs());
      end
    end
    checks++;
    if (n != ACK_TIMEOUT) begin
      errors++; $display("FAIL timeout_len: got %0d cycles expected %0d", n, ACK_TIMEOUT);
    end
    checks++;
    if (lru_state !== 3'd4 || auto_pilot !== 1'b1) begin
      errors++; $display("FAIL timeout_auto: got st=%0d ap=%b expected st=4 ap=1", lru_state, auto_pilot);
    end
    apply_reset();
    drive(0, 1, 2'd0, 0, 12'd2000);
    tick();
    drive(0, 0, 2'd0, 0, 12'd2000);
    repeat (ACK_TIMEOUT - 1) tick();
    drive(0, 0, 2'd0, 1, 12'd2000);
    tick();
    drive(0, 0, 2'd0, 0, 12'd2000);
    checks++;
    if (lru_state !== 3'd4 || auto_pilot !== 1'b0) begin
      errors++; $display("FAIL timeout_ack_wins: got st=%0d ap=%b expected st=4 ap=0", lru_state, auto_pilot);
    end
`else
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL no_timeout cyc %0d: got %b expected %b", i, dut_outs(), model_outs());
      end
    end
    checks++;
    if (lru_state !== 3'd3 || alarm !== 1'b1 || auto_pilot !== 1'b0) begin
      errors++; $display("FAIL no_timeout_hold: got st=%0d alarm=%b ap=%b expected st=3 alarm=1 ap=0",
                         lru_state, alarm, auto_pilot);
    end
`endif
  endtask

  task automatic test_landing();
    int gear_idx;
    int alt;
    gear_idx = -1;
    apply_reset();
    drive(0, 1, 2'd0, 0, 12'd1000);
    tick();
    drive(0, 0, 2'd0, 1, 12'd1000);
    tick();
    for (int k = 0; k <= 10; k++) begin
      alt = 1000 - 100 * k;
      drive(0, 0, 2'd0, 0, 12'(alt));
      tick();
      if (gear_down === 1'b1 && gear_idx < 0) gear_idx = k;
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL landing step %0d: got %b expected %b", k, dut_outs(), model_outs());
      end
    end
    checks++;
    if (gear_idx != 7) begin
      errors++; $display("FAIL gear_timing: got step %0d expected step %0d", gear_idx, 7);
    end
    checks++;
    if (lru_state !== 3'd6 || landing_complete !== 1'b1 || descent_cmd !== 1'b0 || gear_down !== 1'b1) begin
      errors++; $display("FAIL landed: got st=%0d lc=%b dc=%b gd=%b expected st=6 lc=1 dc=0 gd=1",
                         lru_state, landing_complete, descent_cmd, gear_down);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'(i % 2), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 12'($urandom));
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL landed_latch cyc %0d: got %b expected %b", i, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_random_flow();
    int alt;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) begin
        drive(1'($urandom_range(0, 1)), 0, 2'($urandom_range(0, 3)), 0, 12'd4000);
        tick();
        checks++;
        if (dut_outs() !== model_outs()) begin
          errors++; $display("FAIL flow_pre it %0d cyc %0d: got %b expected %b", it, i, dut_outs(), model_outs());
        end
      end
      alt = int'($urandom_range(0, 4095));
      drive(1'($urandom_range(0, 1)), 1, 2'($urandom_range(0, 3)), 0, 12'(alt));
      tick();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 7) == 0) alt = (alt + 200 > 4095) ? 4095 : alt + 200;
        else begin
          alt = alt - int'($urandom_range(0, 400));
          if (alt < 0) alt = 0;
        end
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 29) == 0), 12'(alt));
        tick();
        checks++;
        if (dut_outs() !== model_outs()) begin
          errors++; $display("FAIL flow it %0d cyc %0d: got %b expected %b", it, i, dut_outs(), model_outs());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(0, 1, 2'd0, 0, 12'd200);
    tick();
    drive(0, 0, 2'd0, 1, 12'd200);
    tick();
    drive(0, 0, 2'd0, 0, 12'd200);
    tick();
    checks++;
    if (lru_state !== 3'd5 || gear_down !== 1'b1) begin
      errors++; $display("FAIL reach_gear: got st=%0d gd=%b expected st=5 gd=1", lru_state, gear_down);
    end
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_outs() !== 9'd0) begin
      errors++; $display("FAIL async_reset: got %b expected %b", dut_outs(), 9'd0);
    end
    drive(0, 0, 2'd0, 0, 12'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    checks++;
    if (dut_outs() !== model_outs()) begin
      errors++; $display("FAIL post_reset: got %b expected %b", dut_outs(), model_outs());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_caution();
    test_warning_blink();
    test_random_classifier();
    test_alert_ack();
    test_timeout();
    test_landing();
    test_random_flow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
